// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Contents: parity-mode constants, the receive FSM state type and helpers that
// derive the bit period and counter widths from the build parameters.
package uart_rx_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Clock cycles per line bit (integer division, caller guarantees >= 8).
  function automatic int unsigned calc_cycles_per_bit(input int unsigned clk_hz,
                                                      input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int unsigned calc_cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: optional line inversion, a 2-FF
// synchroniser and the bit sampler.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 majority sampler; when it
// is undefined the sample is simply the synchronised line.
// Ports:
//   clk, resetn  - system clock, asynchronous active-low reset
//   uart_rxd     - raw asynchronous serial line
//   rx_en        - receive enable; when low the synchroniser is held at mark
//   rxd_s        - synchronised (and optionally inverted) line
//   sample_bit   - value the FSM uses at its sample point
module uart_rx_sync #(
  parameter bit INVERTED = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_rxd,
  input  logic rx_en,
  output logic rxd_s,
  output logic sample_bit
);

  logic line_in;
  logic sync1_q;
  logic sync2_q;

  assign line_in = INVERTED ? ~uart_rxd : uart_rxd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else if (!rx_en) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // Two-deep history of rxd_s; at the FSM's sample point (mid-bit + 1) these
  // hold the mid-bit - 1 and mid-bit values, the live rxd_s is mid-bit + 1.
  logic hist1_q;
  logic hist2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  assign sample_bit = (hist2_q & hist1_q) | (hist2_q & sync2_q) | (hist1_q & sync2_q);
`else
  assign sample_bit = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver feeding the S.BUS frame assembler.
// Validates the start bit, shifts DATA_BITS LSB first, checks optional parity
// and STOP_BITS stop bits, and presents each character on a valid/ready port
// together with parity, framing and break flags. Also reports dropped
// characters (overrun) and emits a one-cycle line_idle pulse after IDLE_BITS
// bit-times of continuous mark, used as the inter-frame sync.
// Build option: UART_RX_MAJORITY_EN enables 3-point majority sampling, which
// moves every FSM decision one cycle later.
// Ports:
//   clk, resetn          - system clock, asynchronous active-low reset
//   uart_rxd, uart_rx_en - serial line and receive enable
//   m_data, m_valid      - received character and its valid flag
//   m_ready              - consumer accept
//   m_pe, m_fe, m_break  - parity error, framing error, break for m_data
//   overrun              - one-cycle pulse when a character is dropped
//   line_idle            - one-cycle pulse after a long mark period
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BIT_RATE    = 100_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 2,
  parameter int unsigned STOP_BITS   = 2,
  parameter bit          INVERTED    = 1'b1,
  parameter int unsigned IDLE_BITS   = 20
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 uart_rxd,
  input  logic                 uart_rx_en,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_pe,
  output logic                 m_fe,
  output logic                 m_break,
  output logic                 overrun,
  output logic                 line_idle
);

  localparam int unsigned CYCLES_PER_BIT = calc_cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CNT_W          = calc_cnt_width(CYCLES_PER_BIT - 1);
  localparam int unsigned IDLE_TICKS     = IDLE_BITS * CYCLES_PER_BIT;
  localparam int unsigned IDLE_W         = calc_cnt_width(IDLE_TICKS);
  localparam int unsigned BIT_CNT_W      = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_OFS     = CYCLES_PER_BIT / 2 + 1;
`else
  localparam int unsigned SAMPLE_OFS     = CYCLES_PER_BIT / 2;
`endif

  localparam logic [CNT_W-1:0]     SAMPLE_AT = CNT_W'(SAMPLE_OFS);
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(IDLE_TICKS);
  localparam logic [IDLE_W-1:0]    IDLE_PRE  = IDLE_W'(IDLE_TICKS - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam bit                   HAS_PAR   = (PARITY_MODE != PARITY_NONE);
  localparam bit                   ODD_PAR   = (PARITY_MODE == PARITY_ODD);

  logic rxd_s;
  logic sample_bit;

  uart_rx_sync #(
    .INVERTED(INVERTED)
  ) u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rxd  (uart_rxd),
    .rx_en     (uart_rx_en),
    .rxd_s     (rxd_s),
    .sample_bit(sample_bit)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 fe_q, fe_d;
  logic                 stop0_q, stop0_d;
  logic                 sample_tick;

  logic                 done;
  logic                 done_pe;
  logic                 done_fe;
  logic                 done_brk;
  logic                 stop0_now;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_out_q, brk_q, overrun_q;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 line_idle_q, line_idle_d;

  assign sample_tick = (cnt_q == SAMPLE_AT);

  // Flags for the character completing at the last stop sample.
  assign stop0_now = (bit_cnt_q == '0) ? sample_bit : stop0_q;
  assign done_fe   = fe_q | ~sample_bit;
  assign done_pe   = HAS_PAR && ((^shift_q ^ par_q) != ODD_PAR);
  assign done_brk  = (shift_q == '0) && (!HAS_PAR || !par_q) && !stop0_now;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    fe_d      = fe_q;
    stop0_d   = stop0_q;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The IDLE cycle that sees the falling edge counts as cycle 0 of the start bit.
        cnt_d = '0;
        if (!rxd_s) begin
          state_d   = StStart;
          cnt_d     = CNT_W'(1);
          bit_cnt_d = '0;
          par_d     = 1'b0;
          fe_d      = 1'b0;
          stop0_d   = 1'b0;
        end
      end
      StStart: begin
        if (sample_tick) state_d = sample_bit ? StIdle : StData;
      end
      StData: begin
        if (sample_tick) begin
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (sample_tick) begin
          par_d   = sample_bit;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_tick) begin
          stop0_d = stop0_now;
          fe_d    = done_fe;
          if (bit_cnt_q == STOP_LAST) begin
            // Skip the second half of the last stop bit so back-to-back
            // characters resync on the next start edge.
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!uart_rx_en) begin
      state_d = StIdle;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      fe_q      <= 1'b0;
      stop0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      fe_q      <= fe_d;
      stop0_q   <= stop0_d;
    end
  end

  // Output register and handshake. A completion in the same cycle as an
  // accept replaces the old character; otherwise a held character wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_out_q  <= 1'b0;
      brk_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done) begin
        if (!valid_q || m_ready) begin
          data_q   <= shift_q;
          pe_q     <= done_pe;
          fe_out_q <= done_fe;
          brk_q    <= done_brk;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Idle detector: saturating mark counter, pulse on reaching IDLE_TICKS.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    line_idle_d = 1'b0;
    if (!uart_rx_en || !rxd_s) begin
      idle_cnt_d = '0;
    end else if (state_q == StIdle && idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d  = idle_cnt_q + 1'b1;
      line_idle_d = (idle_cnt_q == IDLE_PRE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q  <= '0;
      line_idle_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      line_idle_q <= line_idle_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_pe      = pe_q;
  assign m_fe      = fe_out_q;
  assign m_break   = brk_q;
  assign overrun   = overrun_q;
  assign line_idle = line_idle_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame in 8E2, non-inverted, 500 cycles/bit.
module tb_uart_rx_frame;

  localparam int unsigned CPB = 500;
  // Start-bit drive to m_valid: mid of last stop bit + 2 sync + 1 register.
  localparam int unsigned LAT = 11 * CPB + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_pe, m_fe, m_break, overrun, line_idle;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc = 0;
  int unsigned ovr_cnt = 0;
  int unsigned idle_pulses = 0;
  int unsigned rise_cyc = 0;
  logic        valid_prev = 1'b0;

  uart_rx_frame #(
    .CLK_HZ     (50_000_000),
    .BIT_RATE   (100_000),
    .DATA_BITS  (8),
    .PARITY_MODE(2),
    .STOP_BITS  (2),
    .INVERTED   (1'b0),
    .IDLE_BITS  (20)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rxd  (uart_rxd),
    .uart_rx_en(uart_rx_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_pe      (m_pe),
    .m_fe      (m_fe),
    .m_break   (m_break),
    .overrun   (overrun),
    .line_idle (line_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (line_idle) idle_pulses <= idle_pulses + 1;
    if (m_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= m_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits in line order: start, data LSB first, parity, stop1, stop2.
  function automatic logic [11:0] mk(input logic [7:0] d, input logic p, input logic s1,
                                     input logic s2);
    return {s2, s1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [11:0] f, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      uart_rxd = f[i];
      wait_cyc(CPB);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic accept();
    m_ready = 1'b1;
    wait_cyc(1);
    m_ready = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned t0;
    int unsigned base;

    resetn     = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    m_ready    = 1'b0;
    wait_cyc(3);
    check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_data", {24'd0, m_data}, 32'd0);
    check_eq("rst_flags", {28'd0, m_pe, m_fe, m_break, overrun}, 32'd0);
    check_eq("rst_idle", {31'd0, line_idle}, 32'd0);
    resetn = 1'b1;
    wait_cyc(2);

    // 0xA5, even parity 0, good stops
    t0 = cyc;
    send_bits(mk(8'hA5, 1'b0, 1'b1, 1'b1), 12);
    check_eq("a5_data", {24'd0, m_data}, 32'hA5);
    check_eq("a5_flags", {29'd0, m_pe, m_fe, m_break}, 32'd0);
    check_eq("a5_latency", rise_cyc - t0, LAT);
    wait_cyc(20);
    check_eq("a5_hold", {31'd0, m_valid}, 32'd1);
    accept();
    check_eq("a5_accepted", {31'd0, m_valid}, 32'd0);

    // 0x01 with wrong even parity
    send_bits(mk(8'h01, 1'b0, 1'b1, 1'b1), 12);
    check_eq("pe_data", {24'd0, m_data}, 32'h01);
    check_eq("pe_flag", {31'd0, m_pe}, 32'd1);
    check_eq("pe_fe", {31'd0, m_fe}, 32'd0);
    accept();

    // second stop bit low
    send_bits(mk(8'h5A, 1'b0, 1'b1, 1'b0), 12);
    check_eq("fe_data", {24'd0, m_data}, 32'h5A);
    check_eq("fe_flags", {29'd0, m_pe, m_fe, m_break}, 32'b010);
    accept();
    wait_cyc(400);
    check_eq("fe_no_ghost", {31'd0, m_valid}, 32'd0);

    // break: everything low
    send_bits(12'h000, 12);
    check_eq("brk_data", {24'd0, m_data}, 32'h00);
    check_eq("brk_flags", {29'd0, m_pe, m_fe, m_break}, 32'b011);
    accept();
    wait_cyc(400);
    check_eq("brk_no_ghost", {31'd0, m_valid}, 32'd0);

    // 200-cycle glitch is rejected at the start-bit midpoint
    uart_rxd = 1'b0;
    wait_cyc(200);
    uart_rxd = 1'b1;
    wait_cyc(600);
    check_eq("glitch_valid", {31'd0, m_valid}, 32'd0);
    send_bits(mk(8'h3C, 1'b0, 1'b1, 1'b1), 12);
    check_eq("3c_data", {24'd0, m_data}, 32'h3C);
    check_eq("3c_flags", {28'd0, m_valid, m_pe, m_fe, m_break}, 32'b1000);
    accept();

    // overrun: consumer stalled over two back-to-back characters
    base = ovr_cnt;
    send_bits(mk(8'h11, 1'b0, 1'b1, 1'b1), 12);
    send_bits(mk(8'h22, 1'b0, 1'b1, 1'b1), 12);
    wait_cyc(2);
    check_eq("ovr_pulses", ovr_cnt - base, 32'd1);
    check_eq("ovr_data", {24'd0, m_data}, 32'h11);
    check_eq("ovr_valid", {31'd0, m_valid}, 32'd1);
    accept();

    // accept on the exact completion cycle of the second character
    send_bits(mk(8'h11, 1'b0, 1'b1, 1'b1), 12);
    base = ovr_cnt;
    fork
      send_bits(mk(8'h22, 1'b0, 1'b1, 1'b1), 12);
      begin
        wait_cyc(LAT - 1);
        m_ready = 1'b1;
        wait_cyc(1);
        m_ready = 1'b0;
      end
    join
    wait_cyc(2);
    check_eq("same_cyc_ovr", ovr_cnt - base, 32'd0);
    check_eq("same_cyc_data", {24'd0, m_data}, 32'h22);
    check_eq("same_cyc_valid", {31'd0, m_valid}, 32'd1);

    // idle detector: one pulse roughly 20 bit-times after the last stop sample
    base = idle_pulses;
    wait_cyc(9000);
    check_eq("idle_early", idle_pulses - base, 32'd0);
    wait_cyc(3000);
    check_eq("idle_once", idle_pulses - base, 32'd1);

    // async reset mid-character while a character is held
    check_eq("pre_rst_valid", {31'd0, m_valid}, 32'd1);
    send_bits(mk(8'h77, 1'b1, 1'b1, 1'b1), 4);
    resetn = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, m_valid}, 32'd0);
    check_eq("midrst_data", {24'd0, m_data}, 32'd0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(600);
    check_eq("post_rst_quiet", {31'd0, m_valid}, 32'd0);
    send_bits(mk(8'h5A, 1'b0, 1'b1, 1'b1), 12);
    check_eq("post_rst_data", {24'd0, m_data}, 32'h5A);
    check_eq("post_rst_flags", {28'd0, m_valid, m_pe, m_fe, m_break}, 32'b1000);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
